// File: rtl/s_cla_pkg.sv
// Shared constants and helpers for the pipelined carry-lookahead subtractor.
package s_cla_pkg;

    localparam int CLA_BLOCK = 4;

    function automatic int cla_stages(input int width);
        return width / CLA_BLOCK;
    endfunction

endpackage

// File: rtl/s_cla_sub_pipe_cla4_slice.sv
// Combinational 4-bit carry-lookahead slice: and-generate, or-propagate, xor sum.
module cla4_slice (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);

    logic [3:0] g;
    logic [3:0] p;
    logic [3:0] c;

    assign g = a & b;
    assign p = a | b;

    // Every carry is flattened from cin so no ripple path runs through the slice.
    assign c[0] = cin;
    assign c[1] = g[0] | (p[0] & cin);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    assign cout = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & cin);

    assign sum = a ^ b ^ c;

endmodule

// File: rtl/s_cla_sub_pipe.sv
// Skewed-pipeline signed subtractor: diff = a - b (WIDTH+1 bits), one 4-bit CLA slice per stage.
// Optional S_CLA_SUB_ADD_MODE_EN adds an op_add input selecting a + b instead.
module s_cla_sub_pipe
    import s_cla_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef S_CLA_SUB_ADD_MODE_EN
    input  logic             op_add,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   diff
);

    localparam int STAGES = cla_stages(WIDTH);

    if ((WIDTH % CLA_BLOCK) != 0 || WIDTH < CLA_BLOCK) begin : g_bad_width
        $error("s_cla_sub_pipe: WIDTH must be a positive multiple of 4");
    end

    logic             adv;
    logic [WIDTH-1:0] b_eff;
    logic             cin0;
    logic             sgn0;
    logic             out_valid_reg;
    logic [WIDTH:0]   diff_reg;

    // Global stall: all stage registers advance together or all hold.
    assign adv      = ~out_valid_reg | out_ready;
    assign in_ready = adv;

`ifdef S_CLA_SUB_ADD_MODE_EN
    assign b_eff = op_add ? b : ~b;
    assign cin0  = ~op_add;
`else
    assign b_eff = ~b;
    assign cin0  = 1'b1;
`endif

    // The operation's effect on the sign bit is folded in at entry, so op_add need not travel.
    assign sgn0 = a[WIDTH-1] ^ b_eff[WIDTH-1];

    for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
        localparam int LO    = CLA_BLOCK * gi;
        localparam int SRC_W = WIDTH - LO;

        logic             v_src;
        logic             c_src;
        logic             s_src;
        logic [SRC_W-1:0] a_src;
        logic [SRC_W-1:0] b_src;
        logic [LO+3:0]    res_new;
        logic [3:0]       sum;
        logic             cout;

        if (gi == 0) begin : g_src
            assign v_src   = in_valid;
            assign c_src   = cin0;
            assign s_src   = sgn0;
            assign a_src   = a;
            assign b_src   = b_eff;
            assign res_new = sum;
        end else begin : g_src
            assign v_src   = g_stage[gi-1].g_reg.st_reg.valid;
            assign c_src   = g_stage[gi-1].g_reg.st_reg.carry;
            assign s_src   = g_stage[gi-1].g_reg.st_reg.sgn;
            assign a_src   = g_stage[gi-1].g_reg.st_reg.a_hi;
            assign b_src   = g_stage[gi-1].g_reg.st_reg.b_hi;
            assign res_new = {sum, g_stage[gi-1].g_reg.st_reg.res};
        end

        cla4_slice u_slice (
            .a   (a_src[3:0]),
            .b   (b_src[3:0]),
            .cin (c_src),
            .sum (sum),
            .cout(cout)
        );

        if (gi < STAGES - 1) begin : g_reg
            // Consumed low operand bits are dropped; finished result bits accumulate.
            typedef struct packed {
                logic             valid;
                logic             carry;
                logic             sgn;
                logic [LO+3:0]    res;
                logic [SRC_W-5:0] a_hi;
                logic [SRC_W-5:0] b_hi;
            } stage_t;

            stage_t st_reg;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    st_reg <= '0;
                end else if (adv) begin
                    st_reg <= '{valid: v_src, carry: cout, sgn: s_src, res: res_new,
                                a_hi: a_src[SRC_W-1:4], b_hi: b_src[SRC_W-1:4]};
                end
            end
        end else begin : g_out
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    out_valid_reg <= 1'b0;
                    diff_reg      <= '0;
                end else if (adv) begin
                    out_valid_reg <= v_src;
                    diff_reg      <= {s_src ^ cout, res_new};
                end
            end
        end
    end

    assign out_valid = out_valid_reg;
    assign diff      = diff_reg;

endmodule
